switch_debounce4: RTL and testbench

SWITCH_DEBOUNCE4 -- requirements
Module: switch_debounce4

---
 rtl/switch_debounce4.sv | 86 ++++++++
 tb/tb_switch_debounce4.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/switch_debounce4.sv
// Four-switch debouncer: per-pin two-flop synchronizers feed one vector-wide
// debounce FSM that commits the 4-bit code once it has held steady long enough.
module switch_debounce4 #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    output logic [3:0] code_out,
    output logic       code_valid,
    output logic       code_changed
);
    // state | meaning
    // IDLE  | synchronized input matches code_out, nothing pending
    // COUNT | candidate vector cand is being timed for a clean window
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] COUNT = 1'b1;

    logic [3:0]       sync1;
    logic [3:0]       s;
    logic [3:0]       cand;
    logic [CNT_W-1:0] cnt;
    logic [0:0]       state;
    logic [1:0]       warm;
    logic             running;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 4'b0000;
            s     <= 4'b0000;
        end else begin
            sync1 <= {A, B, C, D};
            s     <= sync1;
        end
    end

    // Hold the FSM until the synchronizers have refilled with live pin values.
    assign running = (warm == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= COUNT;
            cand         <= 4'b0000;
            cnt          <= '0;
            code_out     <= 4'b0000;
            code_valid   <= 1'b0;
            code_changed <= 1'b0;
            warm         <= 2'd0;
        end else begin
            code_changed <= 1'b0;
            if (!running) begin
                warm <= warm + 2'd1;
            end else begin
                case (state)
                    IDLE: begin
                        if (s != code_out) begin
                            cand  <= s;
                            cnt   <= '0;
                            state <= COUNT;
                        end
                    end
                    COUNT: begin
                        if (s != cand) begin
                            cand <= s;
                            cnt  <= '0;
                        end else if (cnt == CNT_LAST) begin
                            code_out     <= cand;
                            code_valid   <= 1'b1;
                            code_changed <= (cand != code_out) || !code_valid;
                            state        <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_switch_debounce4.sv
// Bench for switch_debounce4: directed vector table for the corner cases, then
// randomized pins and resets checked against a run-length reference model.
module tb_switch_debounce4;
    localparam int DEB = 4;

    logic       clk;
    logic       rst;
    logic [3:0] pins;
    logic [3:0] code_out;
    logic       code_valid;
    logic       code_changed;

    int n_cmp = 0;
    int n_err = 0;

    switch_debounce4 #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk),
        .rst(rst),
        .A(pins[3]),
        .B(pins[2]),
        .C(pins[1]),
        .D(pins[0]),
        .code_out(code_out),
        .code_valid(code_valid),
        .code_changed(code_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] pins;
        int         n;
        logic [3:0] eout;
        logic       evalid;
        logic       echg;
        int         epulses;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic r, input logic [3:0] p, input int n,
                           input logic [3:0] eo, input logic ev, input logic ec,
                           input int ep);
        vec_t v;
        v.rst = r; v.pins = p; v.n = n; v.eout = eo;
        v.evalid = ev; v.echg = ec; v.epulses = ep;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a vector is accepted once the FSM has seen it on
    // DEB+1 consecutive samples (load + DEB clean clocks). The sample at edge
    // n after release is the pin value from edge n-2; sampling starts at edge 4.
    // Reset leaves a virtual 0000 sample already counted.
    logic [3:0] m_out;
    logic       m_valid;
    logic       m_chg;
    logic [3:0] hist0, hist1, smp, run_val;
    int         n_rel;
    int         run_len;

    always @(posedge clk) begin
        if (rst) begin
            m_out = 4'b0000; m_valid = 1'b0; m_chg = 1'b0;
            n_rel = 0; run_val = 4'b0000; run_len = 1;
        end else begin
            n_rel++;
            m_chg = 1'b0;
            if (n_rel >= 4) begin
                smp = hist1;
                if (smp == run_val) run_len++;
                else begin
                    run_val = smp;
                    run_len = 1;
                end
                if (run_len == DEB + 1) begin
                    m_chg   = !m_valid || (run_val != m_out);
                    m_out   = run_val;
                    m_valid = 1'b1;
                end
            end
        end
        hist1 = hist0;
        hist0 = pins;
    end

    initial begin
        int pulses;
        int hold;
        rst  = 1'b1;
        pins = 4'b0000;

        // reset and first commit of 0000
        add_vec(1, 4'b0000, 2, 4'b0000, 0, 0, 0);
        add_vec(0, 4'b0000, 6, 4'b0000, 0, 0, 0);
        add_vec(0, 4'b0000, 1, 4'b0000, 1, 1, 1);
        add_vec(0, 4'b0000, 1, 4'b0000, 1, 0, 0);
        // clean change to 0101
        add_vec(0, 4'b0101, 6, 4'b0000, 1, 0, 0);
        add_vec(0, 4'b0101, 1, 4'b0101, 1, 1, 1);
        add_vec(0, 4'b0101, 3, 4'b0101, 1, 0, 0);
        // D toggling every 2 clocks for 20 clocks
        for (int i = 0; i < 10; i++)
            add_vec(0, (i % 2 == 0) ? 4'b0100 : 4'b0101, 2, 4'b0101, 1, 0, 0);
        add_vec(0, 4'b0100, 6, 4'b0101, 1, 0, 0);
        add_vec(0, 4'b0100, 1, 4'b0100, 1, 1, 1);
        add_vec(0, 4'b0100, 2, 4'b0100, 1, 0, 0);
        // bounce away and back: same-value commit, no pulse
        add_vec(0, 4'b1100, 2, 4'b0100, 1, 0, 0);
        add_vec(0, 4'b0100, 12, 4'b0100, 1, 0, 0);
        // B changes at t, C at t+2
        add_vec(0, 4'b0000, 2, 4'b0100, 1, 0, 0);
        add_vec(0, 4'b0010, 6, 4'b0100, 1, 0, 0);
        add_vec(0, 4'b0010, 1, 4'b0010, 1, 1, 1);
        add_vec(0, 4'b0010, 2, 4'b0010, 1, 0, 0);
        // reset midway through a 1111 window
        add_vec(0, 4'b1111, 3, 4'b0010, 1, 0, 0);
        add_vec(1, 4'b1111, 1, 4'b0000, 0, 0, 0);
        add_vec(0, 4'b1111, 7, 4'b0000, 0, 0, 0);
        add_vec(0, 4'b1111, 1, 4'b1111, 1, 1, 1);
        add_vec(0, 4'b1111, 1, 4'b1111, 1, 0, 0);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            rst  = tbl[i].rst;
            pins = tbl[i].pins;
            pulses = 0;
            repeat (tbl[i].n) begin
                @(posedge clk);
                @(negedge clk);
                if (code_changed) pulses++;
            end
            check($sformatf("vec%0d code_out", i), code_out, tbl[i].eout);
            check($sformatf("vec%0d code_valid", i), code_valid, tbl[i].evalid);
            check($sformatf("vec%0d code_changed", i), code_changed, tbl[i].echg);
            check($sformatf("vec%0d pulses", i), pulses, tbl[i].epulses);
        end

        // randomized phase
        rst = 1'b1;
        pins = 4'($urandom_range(0, 15));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            check($sformatf("rnd%0d code_out", cyc), code_out, m_out);
            check($sformatf("rnd%0d code_valid", cyc), code_valid, m_valid);
            check($sformatf("rnd%0d code_changed", cyc), code_changed, m_chg);
            rst = ($urandom_range(0, 299) == 0);
            if (hold == 0) begin
                if ($urandom_range(0, 2) == 0) pins = 4'($urandom_range(0, 15));
                else pins = pins ^ (4'b0001 << $urandom_range(0, 3));
                hold = $urandom_range(1, 8);
            end else begin
                hold--;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
